aw_wdata_arb_2to1: RTL

AW_WDATA_ARB_2TO1 -- requirements
Module: aw_wdata_arb_2to1

---
 rtl/aw_wdata_arb_2to1_pkg.sv | 32 +++
 rtl/aw_wdata_arb_2to1_rr_arb_2.sv | 18 +
 rtl/aw_wdata_arb_2to1.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/aw_wdata_arb_2to1_pkg.sv
// Shared definitions for the two-master AXI write address/data arbiter:
// FSM encoding, owner encoding, AXI field widths and the beat-counter helper.
package aw_wdata_arb_2to1_pkg;

    localparam int ADDR_W  = 32;
    localparam int ID_W    = 4;
    localparam int BURST_W = 2;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int LOCK_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_M1 = 1'b0,
        OWNER_M2 = 1'b1
    } owner_e;

    // Beat counter holds at its maximum instead of wrapping.
    function automatic logic [LEN_W-1:0] beat_inc(input logic [LEN_W-1:0] cnt);
        return (cnt == {LEN_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/aw_wdata_arb_2to1_rr_arb_2.sv
// Two-request round-robin tie-break: a lone request wins outright, a tie goes
// to the master that did not own the previous burst.
module rr_arb_2
    import aw_wdata_arb_2to1_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_owner_i == OWNER_M2) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/aw_wdata_arb_2to1.sv
// Two-master to one-slave AXI write arbiter: one burst at a time, address then
// data phase, with burst-length checking. Valid, ready and payload are unbuffered.
module aw_wdata_arb_2to1
    import aw_wdata_arb_2to1_pkg::*;
(
    input  logic               aclk,
    input  logic               areset,

    input  logic [ADDR_W-1:0]  awaddr_m1,
    input  logic [ID_W-1:0]    awid_m1,
    input  logic [BURST_W-1:0] awburst_m1,
    input  logic [LEN_W-1:0]   awlen_m1,
    input  logic [SIZE_W-1:0]  awsize_m1,
    input  logic [LOCK_W-1:0]  awlock_m1,
    input  logic [CACHE_W-1:0] awcache_m1,
    input  logic [PROT_W-1:0]  awprot_m1,
    input  logic               awvalid_m1,
    output logic               awready_m1,

    input  logic [ADDR_W-1:0]  awaddr_m2,
    input  logic [ID_W-1:0]    awid_m2,
    input  logic [BURST_W-1:0] awburst_m2,
    input  logic [LEN_W-1:0]   awlen_m2,
    input  logic [SIZE_W-1:0]  awsize_m2,
    input  logic [LOCK_W-1:0]  awlock_m2,
    input  logic [CACHE_W-1:0] awcache_m2,
    input  logic [PROT_W-1:0]  awprot_m2,
    input  logic               awvalid_m2,
    output logic               awready_m2,

    output logic [ADDR_W-1:0]  awaddr_s,
    output logic [ID_W-1:0]    awid_s,
    output logic [BURST_W-1:0] awburst_s,
    output logic [LEN_W-1:0]   awlen_s,
    output logic [SIZE_W-1:0]  awsize_s,
    output logic [LOCK_W-1:0]  awlock_s,
    output logic [CACHE_W-1:0] awcache_s,
    output logic [PROT_W-1:0]  awprot_s,
    output logic               awvalid_s,
    input  logic               awready_s,

    input  logic [ID_W-1:0]    wid_m1,
    input  logic [DATA_W-1:0]  wdata_m1,
    input  logic [STRB_W-1:0]  wstrb_m1,
    input  logic               wlast_m1,
    input  logic               wvalid_m1,
    output logic               wready_m1,

    input  logic [ID_W-1:0]    wid_m2,
    input  logic [DATA_W-1:0]  wdata_m2,
    input  logic [STRB_W-1:0]  wstrb_m2,
    input  logic               wlast_m2,
    input  logic               wvalid_m2,
    output logic               wready_m2,

    output logic [ID_W-1:0]    wid_s,
    output logic [DATA_W-1:0]  wdata_s,
    output logic [STRB_W-1:0]  wstrb_s,
    output logic               wlast_s,
    output logic               wvalid_s,
    input  logic               wready_s,

    output logic [1:0]         grant,
    output logic               len_err
);

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    owner_e            last_owner_q, last_owner_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;

    logic [1:0]        arb_gnt;
    logic              owner_m2;
    logic              sel_awvalid;
    logic              sel_wvalid;
    logic              aw_hs;
    logic              w_hs;
    logic [1:0]        awready_m;
    logic [1:0]        wready_m;

    rr_arb_2 u_rr_arb_2 (
        .req_i        ({awvalid_m2, awvalid_m1}),
        .last_owner_i (last_owner_q),
        .gnt_o        (arb_gnt)
    );

    // grant_q is zero when idle, so the payload muxes fall back to m1.
    assign owner_m2    = grant_q[1];
    assign sel_awvalid = owner_m2 ? awvalid_m2 : awvalid_m1;
    assign sel_wvalid  = owner_m2 ? wvalid_m2  : wvalid_m1;

    assign awaddr_s  = owner_m2 ? awaddr_m2  : awaddr_m1;
    assign awid_s    = owner_m2 ? awid_m2    : awid_m1;
    assign awburst_s = owner_m2 ? awburst_m2 : awburst_m1;
    assign awlen_s   = owner_m2 ? awlen_m2   : awlen_m1;
    assign awsize_s  = owner_m2 ? awsize_m2  : awsize_m1;
    assign awlock_s  = owner_m2 ? awlock_m2  : awlock_m1;
    assign awcache_s = owner_m2 ? awcache_m2 : awcache_m1;
    assign awprot_s  = owner_m2 ? awprot_m2  : awprot_m1;

    assign wid_s   = owner_m2 ? wid_m2   : wid_m1;
    assign wdata_s = owner_m2 ? wdata_m2 : wdata_m1;
    assign wstrb_s = owner_m2 ? wstrb_m2 : wstrb_m1;
    assign wlast_s = owner_m2 ? wlast_m2 : wlast_m1;

    assign awvalid_s = (state_q == ADDR) && sel_awvalid;
    assign wvalid_s  = (state_q == DATA) && sel_wvalid;
    assign aw_hs     = awvalid_s && awready_s;
    assign w_hs      = wvalid_s && wready_s;

    // Length check compares the pre-increment beat index against awlen.
    assign len_err = w_hs && (wlast_s ^ (beat_cnt_q == len_q));

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign awready_m[gi] = (state_q == ADDR) && grant_q[gi] && awready_s;
        assign wready_m[gi]  = (state_q == DATA) && grant_q[gi] && wready_s;
    end

    assign awready_m1 = awready_m[0];
    assign awready_m2 = awready_m[1];
    assign wready_m1  = wready_m[0];
    assign wready_m2  = wready_m[1];
    assign grant      = grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;

        case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    grant_d = arb_gnt;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // A dropped awvalid here simply parks the FSM with the grant held.
                if (aw_hs) begin
                    len_d      = awlen_s;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    beat_cnt_d = beat_inc(beat_cnt_q);
                    if (wlast_s) begin
                        state_d      = IDLE;
                        grant_d      = 2'b00;
                        last_owner_d = owner_m2 ? OWNER_M2 : OWNER_M1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= OWNER_M2;
            beat_cnt_q   <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
        end
    end

endmodule
